// File: rtl/muldiv_sched.sv
// HI/LO multiply/divide sequencer: computes into a shadow register at accept
// and commits HI/LO after a fixed per-op latency, raising busy meanwhile.
module muldiv_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] shi_q, shi_d;
    logic [31:0] slo_q, slo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        acc;
    logic        sgn;
    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] div_n, div_d, div_s;
    logic [31:0] uq, ur, q, r;

    // Signed divide runs on magnitudes; INT_MIN/-1 falls out as 0x80000000 r 0.
    always_comb begin
        sgn   = (op == OP_DIV);
        ext_a = (op == OP_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
        ext_b = (op == OP_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
        prod  = ext_a * ext_b;
        div_n = (sgn && a[31]) ? (~a + 32'd1) : a;
        div_d = (sgn && b[31]) ? (~b + 32'd1) : b;
        div_s = (div_d == 32'd0) ? 32'd1 : div_d;
        uq    = div_n / div_s;
        ur    = div_n % div_s;
        q     = (sgn && (a[31] ^ b[31])) ? (~uq + 32'd1) : uq;
        r     = (sgn && a[31]) ? (~ur + 32'd1) : ur;
    end

    assign acc = start & ~cancel & (state_q == IDLE)
               & (op != 3'd0) & (op != 3'd7);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shi_d   = shi_q;
        slo_d   = slo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (acc) begin
                unique case (1'b1)
                    (op == OP_MULT) || (op == OP_MULTU): begin
                        state_d = RUN;
                        cnt_d   = 4'(MULT_CYCLES);
                        shi_d   = prod[63:32];
                        slo_d   = prod[31:0];
                    end
                    (op == OP_DIV) || (op == OP_DIVU): begin
                        state_d = RUN;
                        cnt_d   = 4'(DIV_CYCLES);
                        // Divide by zero commits the current HI/LO back.
                        shi_d   = (b == 32'd0) ? hi_q : r;
                        slo_d   = (b == 32'd0) ? lo_q : q;
                    end
                    (op == OP_MTHI): hi_d = a;
                    (op == OP_MTLO): lo_d = a;
                    default: ;
                endcase
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                hi_d    = shi_q;
                lo_d    = slo_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            shi_q   <= 32'd0;
            slo_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shi_q   <= shi_d;
            slo_q   <= slo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: latency, arithmetic, cancel gating,
// RUN-time start rejection and asynchronous reset.
module tb_muldiv_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        cancel;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .cancel(cancel),
        .busy(busy), .hi(hi), .lo(lo), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic c);
        start = 1'b1; op = o; a = x; b = y; cancel = c;
        step();
        start = 1'b0; op = 3'd0; cancel = 1'b0;
    endtask

    task automatic run_busy(input int n, input logic [31:0] h0,
                            input logic [31:0] l0);
        for (int i = 0; i < n; i++) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            check("done_run", {31'd0, done}, 32'd0);
            check("hi_hold", hi, h0);
            check("lo_hold", lo, l0);
            step();
        end
    endtask

    task automatic commit(input string tag, input logic [31:0] h,
                          input logic [31:0] l);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_hi"}, hi, h);
        check({tag, "_lo"}, lo, l);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0;
        a = 32'd0; b = 32'd0; cancel = 1'b0;
        step(); step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b1;
        step();

        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_busy(5, 32'd0, 32'd0);
        commit("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        step();
        check("mult_done_1cyc", {31'd0, done}, 32'd0);

        issue(3'd4, 32'd7, 32'd2, 1'b0);
        run_busy(10, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        commit("divu", 32'd1, 32'd3);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_busy(10, 32'd1, 32'd3);
        commit("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(3'd5, 32'h11, 32'd0, 1'b0);
        check("mthi", hi, 32'h11);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd6, 32'h22, 32'd0, 1'b0);
        check("mtlo", lo, 32'h22);
        issue(3'd3, 32'd5, 32'd0, 1'b0);
        run_busy(10, 32'h11, 32'h22);
        commit("divz", 32'h11, 32'h22);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_busy(10, 32'h11, 32'h22);
        commit("divov", 32'd0, 32'h8000_0000);

        issue(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1);
        check("mthi_cancel_hi", hi, 32'd0);
        check("mthi_cancel_busy", {31'd0, busy}, 32'd0);
        issue(3'd1, 32'd9, 32'd9, 1'b1);
        check("mult_cancel_busy", {31'd0, busy}, 32'd0);
        issue(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
        check("mthi_hi", hi, 32'hDEAD_BEEF);

        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_busy(1, 32'hDEAD_BEEF, 32'h8000_0000);
        cancel = 1'b1;
        run_busy(1, 32'hDEAD_BEEF, 32'h8000_0000);
        cancel = 1'b0;
        start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3;
        run_busy(1, 32'hDEAD_BEEF, 32'h8000_0000);
        start = 1'b0; op = 3'd0;
        run_busy(2, 32'hDEAD_BEEF, 32'h8000_0000);
        commit("multu", 32'hFFFF_FFFE, 32'h0000_0001);
        step();
        check("multu_no_extra", {31'd0, busy}, 32'd0);
        check("multu_hi_keep", hi, 32'hFFFF_FFFE);

        issue(3'd3, 32'd100, 32'd7, 1'b0);
        run_busy(3, 32'hFFFF_FFFE, 32'h0000_0001);
        reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        step();
        reset = 1'b1;
        step();
        issue(3'd1, 32'd6, 32'd7, 1'b0);
        run_busy(5, 32'd0, 32'd0);
        commit("mult_post", 32'd0, 32'd42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Multi-cycle sequencer for the HI/LO multiply/divide resource in the P7 five-stage MIPS core. It accepts one operation per request from the E stage, computes the result in a shadow register, and holds `busy` for a fixed latency. It commits HI/LO only at the end of that latency. Starts from an instruction flushed by an interrupt/exception request are suppressed, so the hazard unit can stall D-stage HI/LO users on `start | busy`.

## Interface
- `MULT_CYCLES`, 5, busy duration for mult/multu (legal range 1..15)
- `DIV_CYCLES`, 10, busy duration for div/divu (legal range 1..15)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `start`  in  1  E-stage request qualifier; op valid this cycle
- `op`  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (ignored)
- `a`  in  32  forwarded rs operand (E_ALUA)
- `b`  in  32  forwarded rt operand
- `cancel`  in  1  interrupt/exception request (`req`); E-stage instruction is being flushed
- `busy`  out  1  multi-cycle operation in flight
- `hi`  out  32  architectural HI
- `lo`  out  32  architectural LO
- `done`  out  1  one-cycle pulse on the cycle HI/LO become valid after mult/div

## Operation
- States: IDLE, RUN. A 4-bit down-counter `cnt` and 64-bit shadow `{shi,slo}` are used in RUN.
- Accept condition: `acc = start & ~cancel & (state==IDLE) & (op!=0) & (op!=7)`.
- IDLE, `acc` with op 1..4:
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES and go to RUN.
  - Compute the shadow from `a`,`b` in the accept cycle.
- IDLE, `acc` with op 5/6: write `a` into HI/LO at that edge. No busy, no `done`. State stays IDLE.
- RUN:
  - Decrement `cnt` each cycle.
  - When `cnt==1`: HI<=shi, LO<=slo, pulse `done`, go to IDLE.
- Arithmetic:
  - mult: 64-bit signed product, HI=[63:32], LO=[31:0].
  - multu: unsigned product.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of `a`.
  - divu: unsigned quotient and remainder.
  - div/divu with b==0: the full latency still runs; HI/LO remain unchanged at commit; `done` still pulses.
  - div with 0x80000000 / -1: LO=0x80000000, HI=0, no exception.
- `start` while in RUN is ignored. The hazard unit guarantees this never happens in legal flow; the bench still checks it.
- `cancel` only gates acceptance. An operation already in RUN belongs to a retired-path instruction and completes normally. The same applies to `cancel` arriving mid-RUN.
- `cancel` and `start` in the same cycle: nothing is accepted. This covers mthi/mtlo too.
- Reset mid-RUN: state returns to IDLE, `cnt`=0, HI/LO=0, shadow discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0.
- Accept at edge ending cycle T with latency N:
  - `busy`=1 during cycles T+1..T+N.
  - `hi`/`lo` new and `busy`=0 from cycle T+N+1.
  - `done`=1 in cycle T+N+1 only.
- `busy` is a registered output (state!=IDLE). Combinationally it does not depend on `start`; the hazard unit ORs in `start` itself.
- mthi/mtlo accepted in cycle T are visible on `hi`/`lo` in cycle T+1.
- Back-to-back: a new op can be accepted in cycle T+N+1, the first cycle `busy`=0.
- `hi`/`lo` never change during RUN; readers see the old values until commit.

## Test plan
- Reset asserted (0) mid-RUN of div → `busy`, `hi`, `lo`, `done` go to 0 immediately (asynchronous). After release, the next mult is accepted normally.
- mult a=0xFFFFFFFE (-2), b=3 at T → `busy` high T+1..T+5. At T+6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, `done`=1 for one cycle.
- divu a=7, b=2, followed at T+11 by div a=0xFFFFFFF9 (-7), b=2:
  - first op: hi=1, lo=3 at T+11.
  - second op: hi=0xFFFFFFFF, lo=0xFFFFFFFD at T+22.
- div b=0 with prior hi=0x11, lo=0x22 → `busy` for 10 cycles, `done` pulses, hi/lo remain 0x11/0x22.
- mthi a=0xDEADBEEF with `cancel`=1 in the same cycle → hi unchanged, `busy` stays 0. Repeated with `cancel`=0 → hi=0xDEADBEEF the next cycle.
- multu 0xFFFFFFFF×0xFFFFFFFF started, then `cancel`=1 in cycle T+2 and `start`/mult asserted in T+3:
  - running op completes with hi=0xFFFFFFFE, lo=0x00000001 at T+6.
  - the T+3 start is ignored (no extra busy period).
